// File: rtl/input_debounce_edge_pkg.sv
// Shared types and defaults for the input debounce/edge stage.
package input_debounce_edge_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage : input_debounce_edge_pkg

// File: rtl/input_debounce_edge_sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule : sync_2ff

// File: rtl/input_debounce_edge.sv
// Debounces an asynchronous input: synchronise, require STABLE_CYCLES matching
// samples, then emit a clean level plus one-cycle rise/fall pulses.
module input_debounce_edge
  import input_debounce_edge_pkg::*;
#(
  parameter  int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter  int unsigned GLITCH_W      = 8,
  localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_raw,
  output logic                in_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [CNT_W-1:0]    stable_cnt,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  logic sync2;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_raw),
    .q     (sync2)
  );

  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_clean_q, in_clean_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                cnt_done;
  logic                glitch_inc;

  assign cnt_done = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_clean_d = in_clean_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;

    unique case (state_q)
      LOW: begin
        if (sync2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_d    = LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_done) begin
          state_d    = HIGH;
          cnt_d      = '0;
          in_clean_d = 1'b1;
          rise_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!sync2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_d    = HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_done) begin
          state_d    = LOW;
          cnt_d      = '0;
          in_clean_d = 1'b0;
          fall_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase

    // Saturating: the counter holds at all-ones once full.
    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOW;
      cnt_q      <= '0;
      in_clean_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitch_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_clean_q <= in_clean_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      glitch_q   <= glitch_d;
    end
  end

  assign in_clean   = in_clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign stable_cnt = cnt_q;
  assign glitch_cnt = glitch_q;

endmodule : input_debounce_edge
